// File: rtl/freq_meter_if.sv
// -----------------------------------------------------------------------------
// freq_meter_if : result handshake between freq_meter and its consumer.
//   period        measured period in clk cycles         (master -> slave)
//   period_valid  period holds an unconsumed result     (master -> slave)
//   period_ready  consumer accepts the result           (slave  -> master)
//   high_cnt      high time of the same period, only with FREQ_METER_DUTY_EN
// Optional feature macro: FREQ_METER_DUTY_EN
// -----------------------------------------------------------------------------
interface freq_meter_if #(
    parameter int CNT_W = 24
);
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             period_ready;
`ifdef FREQ_METER_DUTY_EN
    logic [CNT_W-1:0] high_cnt;
`endif

    modport master (
        input  period_ready,
        output period,
        output period_valid
`ifdef FREQ_METER_DUTY_EN
        ,
        output high_cnt
`endif
    );

    modport slave (
        output period_ready,
        input  period,
        input  period_valid
`ifdef FREQ_METER_DUTY_EN
        ,
        input  high_cnt
`endif
    );
endinterface

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter : measures the period of a slow asynchronous square wave in
// fast-clock cycles and hands each result out on a valid/ready interface.
//   i_clk        fast system clock
//   i_rst_n      asynchronous active-low reset
//   i_sig_in     slow signal to measure (asynchronous)
//   i_clear_ovr  one-cycle pulse clearing o_overrun
//   o_overrun    sticky: a result was overwritten before it was accepted
//   o_timeout    no rising edge for TIMEOUT_CYC cycles (level)
//   m_res        result port (period / period_valid / period_ready [/ high_cnt])
// Optional feature macro: FREQ_METER_DUTY_EN adds the high-time result.
// -----------------------------------------------------------------------------
module freq_meter #(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_sig_in,
    input  logic          i_clear_ovr,
    output logic          o_overrun,
    output logic          o_timeout,
    freq_meter_if.master  m_res
);

    typedef enum logic {ST_IDLE, ST_MEAS} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_period;
    logic             r_vld, r_ovr, r_to;
    logic             w_edge, w_load, w_to_set, w_to_clr;

    // Fixed synchroniser + edge latency, so edge spacing equals sig_in spacing.
    assign w_edge = r_s2 & ~r_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // cnt is 1 in the cycle after an edge, so on the next edge it equals the
    // number of cycles between the two edges. It stops at TIMEOUT_CYC.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_to_set    = 1'b0;
        w_to_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_MEAS;
                    w_to_clr    = 1'b1;
                end
            end
            ST_MEAS: begin
                if (w_edge) begin
                    w_load    = 1'b1;
                    w_cnt_nxt = CNT_W'(1);
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC)) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period <= '0;
            r_vld    <= 1'b0;
            r_ovr    <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            if (w_load)
                r_period <= r_cnt;
            // A load in the transfer cycle keeps valid high.
            if (w_load)
                r_vld <= 1'b1;
            else if (m_res.period_ready)
                r_vld <= 1'b0;
            // Set has priority over clear.
            if (w_load && r_vld && !m_res.period_ready)
                r_ovr <= 1'b1;
            else if (i_clear_ovr)
                r_ovr <= 1'b0;
            if (w_to_set)
                r_to <= 1'b1;
            else if (w_to_clr)
                r_to <= 1'b0;
        end
    end

`ifdef FREQ_METER_DUTY_EN
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_high;

    // Counting only in MEAS keeps a stuck-high input from wrapping the counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_high <= '0;
        end else begin
            if (w_to_set)
                r_hcnt <= '0;
            else if (w_edge)
                r_hcnt <= CNT_W'(1);
            else if (r_state == ST_MEAS && r_s2)
                r_hcnt <= r_hcnt + CNT_W'(1);
            if (w_load)
                r_high <= r_hcnt;
        end
    end

    assign m_res.high_cnt = r_high;
`endif

    assign m_res.period       = r_period;
    assign m_res.period_valid = r_vld;
    assign o_overrun          = r_ovr;
    assign o_timeout          = r_to;

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;
    localparam int CNT_W = 16;
    localparam int TO    = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sig_in = 1'b0;
    logic clear_ovr = 1'b0;
    logic ready = 1'b0;
    logic overrun, timeout;

    freq_meter_if #(.CNT_W(CNT_W)) res_if ();
    assign res_if.period_ready = ready;

    freq_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sig_in    (sig_in),
        .i_clear_ovr (clear_ovr),
        .o_overrun   (overrun),
        .o_timeout   (timeout),
        .m_res       (res_if.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Reference model: results are the spacing of sig_in rising edges, dropped
    // for the first edge after reset and for any gap longer than TO.
    int qp[$];
    int qh[$];
    bit armed = 1'b0;
    int last_rise = 0;
    int last_high = 0;

    task automatic mdl_rise(input int t);
        if (armed && (t - last_rise) <= TO) begin
            qp.push_back(t - last_rise);
            qh.push_back(last_high);
        end
        armed     = 1'b1;
        last_rise = t;
    endtask

    task automatic mdl_fall(input int t);
        last_high = t - last_rise;
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 sig_in = 1'b1; mdl_rise(cyc);
            repeat (h - 1) @(posedge clk);
            @(posedge clk); #1 sig_in = 1'b0; mdl_fall(cyc);
            repeat (l - 1) @(posedge clk);
        end
    endtask

    // Edge with ready/clear_ovr lined up with the cycle the result loads.
    task automatic same_cyc(input logic rv);
        @(posedge clk); #1 sig_in = 1'b1; mdl_rise(cyc);
        @(posedge clk);
        @(posedge clk); #1 ready = rv; clear_ovr = 1'b1;
        @(posedge clk); #1 ready = 1'b0; clear_ovr = 1'b0;
        chk("sc_period", res_if.period, qp[$]);
        chk("sc_valid", res_if.period_valid, 1);
        chk("sc_overrun", overrun, rv ? 0 : 1);
        repeat (10) @(posedge clk);
        #1 sig_in = 1'b0; mdl_fall(cyc);
        repeat (12) @(posedge clk);
    endtask

    bit   mon_en = 1'b0;
    logic prev_vld = 1'b0;

    always @(negedge clk) begin
        if (rst_n && mon_en && res_if.period_valid && ready) begin
            chk("vld1cyc", prev_vld, 0);
            if (qp.size() == 0) begin
                chk("unexp_vld", res_if.period_valid, 0);
            end else begin
                chk("period", res_if.period, qp[0]);
`ifdef FREQ_METER_DUTY_EN
                chk("high_cnt", res_if.high_cnt, qh[0]);
`endif
                void'(qp.pop_front());
                void'(qh.pop_front());
            end
        end
        prev_vld = res_if.period_valid;
    end

    initial begin
        int guard;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", res_if.period, 0);
        chk("rst_valid", res_if.period_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        ready = 1'b1;
        mon_en = 1'b1;

        // 13/13 wave, always ready
        wave(13, 13, 4);
        chk("w26_overrun", overrun, 0);
        chk("w26_timeout", timeout, 0);

        // overrun: two results without ready
        mon_en = 1'b0;
        ready  = 1'b0;
        qp.delete(); qh.delete();
        wave(13, 13, 2);
        chk("ovr_set", overrun, 1);
        chk("ovr_valid", res_if.period_valid, 1);
        chk("ovr_period", res_if.period, qp[$]);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        chk("ovr_vld_drop", res_if.period_valid, 0);
        @(posedge clk); #1 clear_ovr = 1'b1;
        @(posedge clk); #1 clear_ovr = 1'b0;
        @(negedge clk);
        chk("ovr_clear", overrun, 0);

        // same-cycle load / ready / clear_ovr
        wave(13, 13, 2);
        chk("sc_pre_ovr", overrun, 1);
        same_cyc(1'b1);
        same_cyc(1'b0);
        @(posedge clk); #1 ready = 1'b1; clear_ovr = 1'b1;
        @(posedge clk); #1 clear_ovr = 1'b0;
        @(posedge clk); #1;
        chk("drain_ovr", overrun, 0);
        qp.delete(); qh.delete();
        mon_en = 1'b1;

        // period change 26 -> 8
        wave(13, 13, 2);
        wave(4, 4, 5);

        // randomized wave shapes, including the 1/1 minimum
        wave(1, 1, 3);
        for (int i = 0; i < 20; i++)
            wave($urandom_range(30, 1), $urandom_range(30, 1), 1);

        // timeout
        wave(10, 10, 2);
        guard = 0;
        while (cyc < last_rise + TO + 2 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("to_wait_bound", guard < 300, 1);
        chk("to_early", timeout, 0);
        @(negedge clk);
        chk("to_set", timeout, 1);
        chk("to_no_vld", res_if.period_valid, 0);
        @(posedge clk); #1 sig_in = 1'b1; mdl_rise(cyc);
        repeat (4) @(negedge clk);
        chk("to_clear", timeout, 0);
        repeat (7) @(posedge clk);
        #1 sig_in = 1'b0; mdl_fall(cyc);
        repeat (9) @(posedge clk);
        wave(10, 10, 2);

        // reset mid-period
        @(posedge clk); #1 sig_in = 1'b1; mdl_rise(cyc);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        armed = 1'b0;
        qp.delete(); qh.delete();
        #1;
        chk("mrst_period", res_if.period, 0);
        chk("mrst_valid", res_if.period_valid, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_timeout", timeout, 0);
`ifdef FREQ_METER_DUTY_EN
        chk("mrst_high", res_if.high_cnt, 0);
`endif
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wave(7, 7, 3);

        // flush the last period and confirm every result arrived
        @(posedge clk); #1 sig_in = 1'b1; mdl_rise(cyc);
        repeat (6) @(posedge clk);
        #1;
        chk("q_empty", qp.size(), 0);
        chk("end_overrun", overrun, 0);
        chk("end_timeout", timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Receiving end of the slow-clock path: measures the period of a slow, asynchronous square wave (e.g. clk_slow from the divider) in fast-clock cycles.
- Synchronises the input, detects rising edges, counts fast-clock cycles between successive edges and hands each result out on a valid/ready interface.
- Flags timeout when the input stops toggling, and overrun when a result is lost.

Parameters:
- CNT_W, 24, width of the period counter and the period output.
- TIMEOUT_CYC, 1000000, cycles without a rising edge before timeout; legal range 2 .. 2^CNT_W-1.

Ports:
- clk  input  1  fast system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  slow signal to measure; asynchronous to clk.
- period_ready  input  1  consumer accepts the result.
- clear_ovr  input  1  one-cycle pulse; clears overrun.
- period  output  CNT_W  last measured period, in clk cycles.
- period_valid  output  1  period holds an unconsumed result.
- overrun  output  1  sticky: a result was overwritten before it was accepted.
- timeout  output  1  no rising edge for TIMEOUT_CYC cycles.

Behaviour:
- Reset: all outputs 0, internal counter 0, state IDLE, synchroniser flops 0.
- Synchroniser: two flops, s1 then s2; a third flop s3 holds the previous s2.
- Edge detect: edge = s2 & ~s3. This adds 2-3 cycles of latency from sig_in, identical on every edge, so measured periods are exact.
- State IDLE: waiting for the first edge.
  - On edge: cnt <= 1, go to MEAS, timeout <= 0.
  - No result is produced from this first edge.
- State MEAS, no edge: cnt <= cnt+1.
  - When cnt reaches TIMEOUT_CYC and there is still no edge: timeout <= 1, go to IDLE, cnt <= 0.
  - cnt never wraps, because TIMEOUT_CYC < 2^CNT_W.
- State MEAS, edge: period <= cnt, period_valid <= 1, cnt <= 1, stay in MEAS.
  - Example: a square wave with period N clk cycles gives period = N.
- Timeout is a level, not a pulse: it stays 1 until the next edge, then clears on that edge.
  - The edge after a timeout re-arms only; it produces no result.
- Output handshake:
  - Transfer occurs when period_valid & period_ready. On transfer, period_valid <= 0 on the next cycle unless a new result loads in the same cycle.
  - period is stable while period_valid=1 and no new result loads.
- New result while period_valid=1 and period_ready=0: period is overwritten with the new value, period_valid stays 1, overrun <= 1.
- New result while period_valid=1 and period_ready=1: the new result loads, period_valid stays 1, no overrun.
- overrun is cleared by clear_ovr. If clear_ovr and a new overrun occur in the same cycle, set wins and overrun stays 1.
- Minimum measurable period is 2 clk cycles (1 high / 1 low). Shorter pulses may be missed by the synchroniser; the result is then undefined, but the block must not lock up.
- Reset asserted mid-measurement: immediate return to reset values. The first edge after reset re-arms only.

Optional Feature:
- Macro: FREQ_METER_DUTY_EN.
- When defined:
  - Extra output high_cnt (CNT_W bits, reset 0) and an internal high-time counter.
  - The high-time counter counts cycles with s2=1 since the last rising edge: set to 1 on the edge, +1 while s2=1, held while s2=0.
  - high_cnt loads on the same edge and in the same cycle as period, and follows the same valid/overrun rules.
  - The high-time counter resets to 0 on timeout.
- When undefined: the high_cnt port and its logic are absent; all other behaviour is identical.

Test Plan:
- Wave with 13 cycles high / 13 low, period_ready=1 -> first edge gives no valid; each later edge gives a one-cycle period_valid with period=26; high_cnt=13 when FREQ_METER_DUTY_EN is defined; overrun=0, timeout=0.
- Same wave, period_ready=0 for two periods, then a 1-cycle period_ready -> overrun=1 at the second result and period=26; period_valid drops the cycle after ready; clear_ovr -> overrun=0 next cycle.
- TIMEOUT_CYC=100, wave stopped after one measured period -> timeout=1 exactly 100 cycles after the last edge (in s3 time). The next edge clears timeout and gives no valid; the following edge gives period_valid with the correct period.
- Period changes from 26 to 8 (4 high / 4 low) -> the first result after the change reflects the actual edge spacing; subsequent results give period=8.
- rst_n pulsed low mid-period -> all outputs 0 asynchronously; after release, the first edge gives no valid and the second edge gives the correct period.
- Same cycle: a new result, period_ready=1 and clear_ovr=1 with overrun set -> new period loaded, period_valid=1, overrun=0; repeat with period_ready=0 -> overrun stays 1.
